// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use bubble, redirect squash and memory-stall freeze with a wait watchdog.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1_raddr_ID,
    input  logic [4:0]  rs2_raddr_ID,
    input  logic        rs1_used_ID,
    input  logic        rs2_used_ID,
    input  logic [4:0]  rd_waddr_EX,
    input  logic        rd_wen_EX,
    input  logic [1:0]  PMAItoReg_EX,
    input  logic        branch_taken_EX,
    input  logic        jal_EX,
    input  logic        jalr_EX,
    input  logic        dmem_req_MEM,
    input  logic        dmem_ready_MEM,
    output logic        pc_hold,
    output logic        if_id_hold,
    output logic        id_ex_hold,
    output logic        ex_mem_hold,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mem_err,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_e;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT_CYCLES);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;

    logic mem_stall;
    logic redirect;
    logic load_use;

    assign mem_stall = dmem_req_MEM & ~dmem_ready_MEM;
    assign redirect  = jal_EX | jalr_EX | branch_taken_EX;
    assign load_use  = (PMAItoReg_EX == 2'b01) & rd_wen_EX & (rd_waddr_EX != 5'd0) &
                       ((rs1_used_ID & (rs1_raddr_ID == rd_waddr_EX)) |
                        (rs2_used_ID & (rs2_raddr_ID == rd_waddr_EX)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        pc_hold     = 1'b0;
        if_id_hold  = 1'b0;
        id_ex_hold  = 1'b0;
        ex_mem_hold = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d    = WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            WAIT: begin
                if (!mem_stall) begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == TIMEOUT_C) begin
                    state_d = ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ERR:     state_d = ERR;
            default: state_d = RUN;
        endcase

        // Only the highest-priority hazard drives the pipeline controls.
        if (state_q == ERR || mem_stall) begin
            pc_hold     = 1'b1;
            if_id_hold  = 1'b1;
            id_ex_hold  = 1'b1;
            ex_mem_hold = 1'b1;
        end else if (redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_hold     = 1'b1;
            if_id_hold  = 1'b1;
            id_ex_flush = 1'b1;
        end

        if (!rst_n) begin
            pc_hold     = 1'b0;
            if_id_hold  = 1'b0;
            id_ex_hold  = 1'b0;
            ex_mem_hold = 1'b0;
            if_id_flush = 1'b0;
            id_ex_flush = 1'b0;
        end
    end

    assign mem_err = (state_q == ERR);

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (pc_hold && stall_cnt_q != 32'hFFFF_FFFF)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (if_id_flush && flush_cnt_q != 32'hFFFF_FFFF)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// against a cycle-level reference model of the hazard rules and watchdog.
module tb_hazard_ctrl;
    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1, rs2, rd;
    logic        rs1u, rs2u, rdwen;
    logic [1:0]  pma;
    logic        bt, jal, jalr, req, rdy;
    logic        pc_hold, if_id_hold, id_ex_hold, ex_mem_hold;
    logic        if_id_flush, id_ex_flush, mem_err;
    logic [31:0] stall_cnt, flush_cnt;
    logic [6:0]  obs;

    int checks = 0;
    int fails  = 0;

    // Reference model state: error flag, consecutive unready cycles, event counts.
    bit          m_err;
    int          m_run;
    int unsigned m_scnt, m_fcnt;

    hazard_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_raddr_ID(rs1), .rs2_raddr_ID(rs2),
        .rs1_used_ID(rs1u), .rs2_used_ID(rs2u),
        .rd_waddr_EX(rd), .rd_wen_EX(rdwen), .PMAItoReg_EX(pma),
        .branch_taken_EX(bt), .jal_EX(jal), .jalr_EX(jalr),
        .dmem_req_MEM(req), .dmem_ready_MEM(rdy),
        .pc_hold(pc_hold), .if_id_hold(if_id_hold), .id_ex_hold(id_ex_hold),
        .ex_mem_hold(ex_mem_hold), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    assign obs = {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, if_id_flush, id_ex_flush, mem_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {pc,ifid,idex,exmem holds, ifid,idex flushes, mem_err}.
    function automatic logic [6:0] model_out();
        bit stall, redir, lu;
        if (!rst_n) return 7'b0;
        if (m_err) return 7'b1111_00_1;
        stall = req && !rdy;
        redir = jal || jalr || bt;
        lu = (pma == 2'b01) && rdwen && (rd != 0) &&
             ((rs1u && rs1 == rd) || (rs2u && rs2 == rd));
        if (stall) return 7'b1111_00_0;
        if (redir) return 7'b0000_11_0;
        if (lu)    return 7'b1100_01_0;
        return 7'b0;
    endfunction

    function automatic logic [31:0] exp_scnt();
`ifdef HAZARD_PERF_EN
        return m_scnt;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_fcnt();
`ifdef HAZARD_PERF_EN
        return m_fcnt;
`else
        return 32'd0;
`endif
    endfunction

    task automatic clear_inputs();
        rs1 = 0; rs2 = 0; rd = 0; rs1u = 0; rs2u = 0; rdwen = 0; pma = 0;
        bt = 0; jal = 0; jalr = 0; req = 0; rdy = 0;
    endtask

    task automatic model_reset();
        m_err = 0; m_run = 0; m_scnt = 0; m_fcnt = 0;
    endtask

    // Advance one clock: update the model at the edge, return at the falling edge.
    task automatic tick();
        logic [6:0] e;
        @(posedge clk);
        if (rst_n) begin
            e = model_out();
            if (e[6]) m_scnt++;
            if (e[2]) m_fcnt++;
            if (!m_err) begin
                if (req && !rdy) begin
                    m_run++;
                    if (m_run > TO) m_err = 1;
                end else begin
                    m_run = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0;
        model_reset();
        #2;
        checks++;
        if (obs !== 7'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b want %b", obs, 7'b0);
        end
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        req = 1; jal = 1; pma = 2'b01; rdwen = 1; rd = 3; rs1 = 3; rs1u = 1;
        rst_n = 0;
        model_reset();
        #2;
        checks++;
        if (obs !== 7'b0) begin
            fails++;
            $display("FAIL reset_gate: got %b want %b", obs, 7'b0);
        end
        checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            fails++;
            $display("FAIL reset_counts: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
        tick();
        checks++;
        if (obs !== 7'b0) begin
            fails++;
            $display("FAIL reset_held: got %b want %b", obs, 7'b0);
        end
        clear_inputs();
        rst_n = 1;
        #2;
        checks++;
        if (obs !== 7'b0) begin
            fails++;
            $display("FAIL reset_release_idle: got %b want %b", obs, 7'b0);
        end
        tick();
    endtask

    task automatic test_load_use();
        clear_inputs();
        pma = 2'b01; rdwen = 1; rd = 5; rs2 = 5; rs2u = 1; rs1 = 3; rs1u = 1;
        #2;
        checks++;
        if (obs !== 7'b1100_01_0) begin
            fails++;
            $display("FAIL load_use_rs2: got %b want %b", obs, 7'b1100_01_0);
        end
        tick();
        rdwen = 0; pma = 2'b00;
        #2;
        checks++;
        if (obs !== 7'b0) begin
            fails++;
            $display("FAIL load_use_bubble_once: got %b want %b", obs, 7'b0);
        end
        tick();
        pma = 2'b01; rdwen = 1; rd = 0; rs1 = 0; rs1u = 1; rs2 = 1; rs2u = 1;
        #2;
        checks++;
        if (obs !== 7'b0) begin
            fails++;
            $display("FAIL load_x0: got %b want %b", obs, 7'b0);
        end
        tick();
        rd = 7; rs1 = 7; rs1u = 0; rs2 = 2; rs2u = 1;
        #2;
        checks++;
        if (obs !== 7'b0) begin
            fails++;
            $display("FAIL load_rs1_unused: got %b want %b", obs, 7'b0);
        end
        tick();
        rs1u = 1;
        #2;
        checks++;
        if (obs !== 7'b1100_01_0) begin
            fails++;
            $display("FAIL load_use_rs1: got %b want %b", obs, 7'b1100_01_0);
        end
        tick();
        pma = 2'b00;
        #2;
        checks++;
        if (obs !== 7'b0) begin
            fails++;
            $display("FAIL non_load_match: got %b want %b", obs, 7'b0);
        end
        tick();
    endtask

    task automatic test_redirect();
        clear_inputs();
        pma = 2'b01; rdwen = 1; rd = 9; rs1 = 9; rs1u = 1; jalr = 1;
        #2;
        checks++;
        if (obs !== 7'b0000_11_0) begin
            fails++;
            $display("FAIL jalr_over_load_use: got %b want %b", obs, 7'b0000_11_0);
        end
        tick();
        clear_inputs();
        bt = 1;
        #2;
        checks++;
        if (obs !== 7'b0000_11_0) begin
            fails++;
            $display("FAIL branch_taken: got %b want %b", obs, 7'b0000_11_0);
        end
        tick();
        clear_inputs();
        req = 1; rdy = 1; jal = 1;
        #2;
        checks++;
        if (obs !== 7'b0000_11_0) begin
            fails++;
            $display("FAIL jal_req_ready: got %b want %b", obs, 7'b0000_11_0);
        end
        tick();
    endtask

    task automatic test_stall_redirect();
        clear_inputs();
        req = 1; rdy = 0; jal = 1;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (obs !== 7'b1111_00_0) begin
                fails++;
                $display("FAIL stall_defers_jal[%0d]: got %b want %b", i, obs, 7'b1111_00_0);
            end
            tick();
        end
        rdy = 1;
        #2;
        checks++;
        if (obs !== 7'b0000_11_0) begin
            fails++;
            $display("FAIL jal_after_stall: got %b want %b", obs, 7'b0000_11_0);
        end
        tick();
        // Back in RUN: a stall of exactly TO cycles must complete without error.
        clear_inputs();
        req = 1; rdy = 0;
        for (int i = 0; i < TO; i++) begin
            #2;
            checks++;
            if (obs !== 7'b1111_00_0) begin
                fails++;
                $display("FAIL wait_exact[%0d]: got %b want %b", i, obs, 7'b1111_00_0);
            end
            tick();
        end
        rdy = 1;
        #2;
        checks++;
        if (obs !== 7'b0) begin
            fails++;
            $display("FAIL wait_exact_done: got %b want %b", obs, 7'b0);
        end
        tick();
        clear_inputs();
        #2;
        checks++;
        if (obs !== 7'b0) begin
            fails++;
            $display("FAIL wait_exact_no_err: got %b want %b", obs, 7'b0);
        end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        clear_inputs();
        req = 1; rdy = 0;
        for (int i = 0; i < TO + 1; i++) begin
            #2;
            checks++;
            if (obs !== 7'b1111_00_0) begin
                fails++;
                $display("FAIL timeout_wait[%0d]: got %b want %b", i, obs, 7'b1111_00_0);
            end
            tick();
        end
        #2;
        checks++;
        if (obs !== 7'b1111_00_1) begin
            fails++;
            $display("FAIL timeout_err: got %b want %b", obs, 7'b1111_00_1);
        end
        tick();
        req = 0; jal = 1;
        #2;
        checks++;
        if (obs !== 7'b1111_00_1) begin
            fails++;
            $display("FAIL err_absorbing: got %b want %b", obs, 7'b1111_00_1);
        end
        rst_n = 0;
        model_reset();
        #1;
        checks++;
        if (obs !== 7'b0) begin
            fails++;
            $display("FAIL err_async_clear: got %b want %b", obs, 7'b0);
        end
        tick();
        clear_inputs();
        rst_n = 1;
        tick();
    endtask

    task automatic test_perf();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            clear_inputs();
            pma = 2'b01; rdwen = 1; rd = 6; rs2 = 6; rs2u = 1;
            tick();
            rdwen = 0; pma = 2'b00;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            if (i == 0) jal = 1;
            else if (i == 1) jalr = 1;
            else bt = 1;
            tick();
            clear_inputs();
            tick();
        end
        checks++;
`ifdef HAZARD_PERF_EN
        if (stall_cnt !== 32'd2 || flush_cnt !== 32'd3) begin
            fails++;
            $display("FAIL perf_counts: got %0d/%0d want 2/3", stall_cnt, flush_cnt);
        end
`else
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            fails++;
            $display("FAIL perf_counts: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
`endif
    endtask

    task automatic test_random();
        logic [6:0] e;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            rs1   = 5'($urandom_range(0, 3));
            rs2   = 5'($urandom_range(0, 3));
            rd    = 5'($urandom_range(0, 3));
            rs1u  = 1'($urandom_range(0, 1));
            rs2u  = 1'($urandom_range(0, 1));
            rdwen = ($urandom_range(0, 3) != 0);
            pma   = 2'($urandom_range(0, 3));
            bt    = ($urandom_range(0, 7) == 0);
            jal   = ($urandom_range(0, 7) == 0);
            jalr  = ($urandom_range(0, 7) == 0);
            req   = 1'($urandom_range(0, 1));
            rdy   = ($urandom_range(0, 3) == 0);
            #2;
            e = model_out();
            checks++;
            if (obs !== e) begin
                fails++;
                $display("FAIL random_outputs[%0d]: got %b want %b", n, obs, e);
            end
            checks++;
            if (stall_cnt !== exp_scnt() || flush_cnt !== exp_fcnt()) begin
                fails++;
                $display("FAIL random_counts[%0d]: got %0d/%0d want %0d/%0d",
                         n, stall_cnt, flush_cnt, exp_scnt(), exp_fcnt());
            end
            tick();
            if (m_err && $urandom_range(0, 3) == 0) do_reset();
        end
    endtask

    initial begin
        clear_inputs();
        model_reset();
        rst_n = 1;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_redirect();
        test_stall_redirect();
        test_timeout();
        test_perf();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
